decoder_scan: RTL

- Parametrised, registered N-to-M one-hot decoder; successor to the team's fixed 3-to-8 combinational decoder.
- Adds enable, active-low output option, a latched direct-select mode, and an auto-scan mode that walks the active output at a programmable rate.
- Sits between control logic and board select lines, such as 7-segment digit enables or LED banks.

---
 rtl/decoder_scan.sv | 80 ++++++++
 1 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with latched direct select and auto-scan mode.
// Defining DECODER_SCAN_BLANK_EN blanks the last BLANK_CYC clocks of every scan step.
module decoder_scan #(
   parameter int SEL_W      = 3,
   parameter int OUT_W      = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 0,
   parameter int BLANK_CYC  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic             sel_vld,
   output logic [OUT_W-1:0] out,
   output logic [SEL_W-1:0] cur_idx,
   output logic             step,
   output logic             err
);
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [OUT_W-1:0] INACT = (ACTIVE_LOW != 0) ? '1 : '0;
`ifdef DECODER_SCAN_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
   state_t state, state_n;
   logic [SEL_W-1:0] idx, idx_n;
   logic [PW-1:0] presc, presc_n;
   logic step_n, err_n, in_rng, tc, act;
   logic [OUT_W-1:0] out_n;
   assign in_rng  = {1'b0, sel} < (SEL_W+1)'(OUT_W);
   assign tc      = presc == PW'(SCAN_DIV-1);
   assign cur_idx = idx;
   always_comb begin
      state_n = state;
      idx_n   = idx;
      presc_n = presc;
      step_n  = 1'b0;
      err_n   = err;
      if (!en)
         state_n = IDLE;
      else if (mode) begin
         if (state != SCAN) begin
            state_n = SCAN;
            presc_n = '0;
         end else if (tc) begin
            presc_n = '0;
            idx_n   = (idx == SEL_W'(OUT_W-1)) ? '0 : idx + 1'b1;
            step_n  = 1'b1;
         end else
            presc_n = presc + 1'b1;
      end else begin
         // a strobe arriving with the scan-to-direct switch is honoured
         state_n = (state == IDLE && !(sel_vld && in_rng)) ? IDLE : DIRECT;
         idx_n   = (sel_vld && in_rng) ? sel : idx;
         err_n   = err | (sel_vld & ~in_rng);
      end
      act   = state_n != IDLE && !(state_n == SCAN && BLANK_ON && presc_n >= PW'(SCAN_DIV-BLANK_CYC));
      out_n = act ? ((OUT_W'(1) << idx_n) ^ INACT) : INACT;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         presc <= '0;
         out   <= INACT;
         step  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         presc <= presc_n;
         out   <= out_n;
         step  <= step_n;
         err   <= err_n;
      end
endmodule
